mul_float: RTL and testbench
============================

# mul_float

Sequential IEEE-754 single-precision multiplier and the companion of the float divider in the arithmetic datapath. It takes two 32-bit operands on a start strobe, multiplies the 24-bit mantissas with a one-bit-per-cycle shift-add loop, then normalizes and packs the result. It raises `err` on exponent overflow or underflow. It uses the same sign/exponent/mantissa packing as the divider, so the two can be swapped behind a common start/done wrapper.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request; sampled only while idle.
- `mcand` in 32: multiplicand, IEEE-754 single.
- `mplier` in 32: multiplier, IEEE-754 single.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse; `prod` and `err` are valid from this cycle.
- `prod` out 32: packed product; held until the next accepted `start`.
- `err` out 1: exponent overflow/underflow flag; held with `prod`.

## Operation
- States: IDLE, MUL, PACK.
- IDLE:
  - On `start=1`, capture `s=mcand[31]^mplier[31]`, `e1`, `e2`, `m1={1,mcand[22:0]}` and `m2={1,mplier[22:0]}`.
  - Clear the 48-bit accumulator, load count=0, set busy=1, go to MUL.
- MUL, 24 cycles:
  - If `m2[count]`, add `m1<<count` into the accumulator P.
  - count++. Leave for PACK after count=23.
- PACK, 1 cycle:
  - Compute `prod`, `err`; set done=1, busy=0; return to IDLE.
- Arithmetic:
  - Exponent is a 10-bit signed value: `E = e1 + e2 - 127`.
  - If `P[47]=1`: mantissa = `P[46:24]`, E = E+1, guard = `P[23]`, sticky = OR of `P[22:0]`.
  - Else: mantissa = `P[45:23]`, guard = `P[22]`, sticky = OR of `P[21:0]`.
- Zero operands:
  - If either exponent field is 0, then `prod = {s,31'b0}` and `err=0`.
  - The mantissa result is discarded. No denormal, Inf or NaN handling.
- Overflow/underflow:
  - If E ≥ 255: `err=1`, `prod={s,8'hFF,23'b0}`.
  - If E ≤ 0: `err=1`, `prod={s,31'b0}`.
  - Otherwise `err=0`, `prod={s,E[7:0],mantissa}`.
- `start` while busy is ignored; there is no queueing.
- `start` arriving in the same cycle as `done` is accepted only if the FSM is already in IDLE. In practice the earliest accepted `start` is the cycle after `done`.

## Timing
- Reset values:
  - State IDLE, busy=0, done=0, prod=32'h0, err=0, count=0.
  - The accumulator and captured operands reset to 0.
- Latency: `start` sampled at edge N; MUL covers edges N+1..N+24; PACK at edge N+25 drives `done=1`; `done` falls at N+26. Latency is 25 cycles.
- Throughput: one operation per 26 cycles.
- `rst_n` low mid-operation: immediate return to IDLE with all outputs at reset values; the in-flight result is lost and no `done` is issued.
- Operand inputs may change after the `start` cycle without affecting the result.

## Configuration
- `MUL_FLOAT_ROUND_EN` defined: round-to-nearest-even.
  - Increment the mantissa if `guard & (sticky | mantissa[0])`.
  - Carry-out sets mantissa to 0 and E=E+1.
  - The overflow check is applied after rounding.
- Not defined: truncation; guard and sticky are ignored, matching the divider's behaviour.

## Test plan
- 0x40000000 × 0x40400000 (2.0×3.0) -> `done` exactly 25 cycles after `start`, `prod`=0x40C00000, `err`=0.
- 0xC0000000 × 0x3F000000 (-2.0×0.5) -> `prod`=0xBF800000, `err`=0; and 0x3FC00000 × 0x3FC00000 -> 0x40100000 (normalization carry path).
- 0x3F800001 × 0x3FC00000 -> `prod`=0x3FC00001 without the macro, 0x3FC00002 with `MUL_FLOAT_ROUND_EN`.
- Overflow and underflow:
  - 0x7F000000 × 0x7F000000 -> `err`=1, `prod`=0x7F800000.
  - 0x00800000 × 0x00800000 -> `err`=1, `prod`=0x00000000.
  - 0x00000000 × 0xC0400000 -> `prod`=0x80000000, `err`=0.
- Pulse `start` again on cycle 5 of an operation -> ignored; the first result is unchanged and only one `done` pulse occurs.
- Drop `rst_n` at MUL cycle 10 -> `busy`, `done`, `prod`, `err` all 0 asynchronously. A new `start` after release (2.0×3.0) -> 0x40C00000 after 25 cycles.

Source files
------------

// File: rtl/mul_float.sv
// ----------------------------------------------------------------------------
// mul_float
//   Sequential IEEE-754 single-precision multiplier. Two operands are captured
//   on a start strobe. The 24-bit mantissas are multiplied with a one-bit-per-
//   cycle shift-add loop over 24 cycles. The product is then normalized,
//   optionally rounded, range-checked and packed in a single PACK cycle.
//   Zero exponent fields produce a signed zero. There is no handling of
//   denormals, Inf or NaN.
//
//   Build option:
//     MUL_FLOAT_ROUND_EN  defined     -> round-to-nearest-even on the 23-bit
//                                        mantissa
//                         not defined -> truncation (guard/sticky ignored)
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   start   in   1  one-cycle request, sampled only while idle
//   mcand   in  32  multiplicand (IEEE-754 single)
//   mplier  in  32  multiplier (IEEE-754 single)
//   busy    out  1  high from the cycle after start is accepted until done
//   done    out  1  one-cycle pulse; prod/err valid from this cycle
//   prod    out 32  packed product, held until the next accepted start
//   err     out  1  exponent overflow/underflow flag, held with prod
// ----------------------------------------------------------------------------
module mul_float (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] prod,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        PACK = 2'd2
    } state_t;

    state_t       state;
    logic         sgn;
    logic [7:0]   e1;
    logic [7:0]   e2;
    logic [23:0]  m1;
    logic [23:0]  m2;
    logic [47:0]  acc;
    logic [4:0]   count;

    logic signed [9:0] exp_b;
    logic signed [9:0] exp_n;
    logic [22:0]       mant;
    logic [32:0]       res;     // {err, prod}

`ifdef MUL_FLOAT_ROUND_EN
    logic        guard;
    logic        sticky;
    logic [23:0] rnd;

    // Round-to-nearest-even increment; bit 23 of the result is the carry-out.
    function automatic logic [23:0] round_rne(input logic [22:0] m,
                                              input logic        g,
                                              input logic        st);
        return {1'b0, m} + {23'd0, g & (st | m[0])};
    endfunction
`endif

    // Range check and packing: saturate to signed Inf-pattern on overflow,
    // signed zero on underflow; both raise err.
    function automatic logic [32:0] sat_pack(input logic              s,
                                             input logic signed [9:0] e,
                                             input logic [22:0]       m);
        if (e >= 10'sd255)
            return {1'b1, s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            return {1'b1, s, 31'd0};
        else
            return {1'b0, s, e[7:0], m};
    endfunction

    // ---- normalize / round / pack (combinational, registered in PACK) ----
    always_comb begin
        exp_b = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;
        exp_n = exp_b;
        mant  = acc[45:23];
        if (acc[47]) begin
            mant  = acc[46:24];
            exp_n = exp_b + 10'sd1;
        end
`ifdef MUL_FLOAT_ROUND_EN
        guard  = acc[47] ? acc[23]   : acc[22];
        sticky = acc[47] ? |acc[22:0] : |acc[21:0];
        rnd    = round_rne(mant, guard, sticky);
        if (rnd[23]) begin
            mant  = 23'd0;
            exp_n = exp_n + 10'sd1;
        end else begin
            mant  = rnd[22:0];
        end
`endif
        if (e1 == 8'd0 || e2 == 8'd0)
            res = {1'b0, sgn, 31'd0};
        else
            res = sat_pack(sgn, exp_n, mant);
    end

    // ---- control FSM and datapath registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            prod  <= 32'd0;
            err   <= 1'b0;
            count <= 5'd0;
            sgn   <= 1'b0;
            e1    <= 8'd0;
            e2    <= 8'd0;
            m1    <= 24'd0;
            m2    <= 24'd0;
            acc   <= 48'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sgn   <= mcand[31] ^ mplier[31];
                        e1    <= mcand[30:23];
                        e2    <= mplier[30:23];
                        m1    <= {1'b1, mcand[22:0]};
                        m2    <= {1'b1, mplier[22:0]};
                        acc   <= 48'd0;
                        count <= 5'd0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (m2[count])
                        acc <= acc + ({24'd0, m1} << count);
                    count <= count + 5'd1;
                    if (count == 5'd23)
                        state <= PACK;
                end
                PACK: begin
                    prod  <= res[31:0];
                    err   <= res[32];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    count <= 5'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_float.sv
module tb_mul_float;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] prod;
    logic        err;

    int total;
    int bad;

    mul_float dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mcand  (mcand),
        .mplier (mplier),
        .busy   (busy),
        .done   (done),
        .prod   (prod),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one operation and wait for done (bounded). Operands are
    // scrambled right after the start edge to show they were captured.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ep, input logic ee);
        int k;
        @(negedge clk);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = 32'h12345678;
        mplier = 32'h9ABCDEF0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_lat"}, k, 25);
        chk({tag, "_prod"}, prod, ep);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
        @(posedge clk);
        #1;
        chk({tag, "_donefall"}, {30'd0, done, busy}, 32'd0);
    endtask

    logic [31:0] exp_rnd;
    int ndone;

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        mcand  = 32'd0;
        mplier = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_prod", prod, 32'd0);
        chk("rst_err",  {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul2x3",   32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
        run_op("neg2xhalf", 32'hC0000000, 32'h3F000000, 32'hBF800000, 1'b0);
        run_op("norm15",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0);
`ifdef MUL_FLOAT_ROUND_EN
        exp_rnd = 32'h3FC00002;
`else
        exp_rnd = 32'h3FC00001;
`endif
        run_op("round",    32'h3F800001, 32'h3FC00000, exp_rnd, 1'b0);
        run_op("ovf",      32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1);
        run_op("unf",      32'h00800000, 32'h00800000, 32'h00000000, 1'b1);
        run_op("zero",     32'h00000000, 32'hC0400000, 32'h80000000, 1'b0);

        // Restart while busy: second start on cycle 5 must be ignored.
        @(negedge clk);
        mcand  = 32'h40000000;
        mplier = 32'h40400000;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        mcand  = 32'h3FC00000;
        mplier = 32'h3FC00000;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        ndone  = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("busy_ign_prod",  prod, 32'h40C00000);
        chk("busy_ign_ndone", ndone, 1);

        // Async reset in the middle of MUL.
        @(negedge clk);
        mcand  = 32'h40000000;
        mplier = 32'h40400000;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_prod", prod, 32'd0);
        chk("arst_err",  {31'd0, err}, 32'd0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("arst_nodone", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
